ff_bank_sequencer: RTL and testbench

//  Controller that shares one WIDTH-bit bank of flip-flops between two requesters.

---
 rtl/ff_bank_sequencer.sv | 119 +++++++++++
 tb/tb_ff_bank_sequencer.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ff_bank_sequencer.sv
// Shares one WIDTH-bit flip-flop bank between two requesters: round-robin grant,
// one-cycle apply of LOAD/SET/CLEAR/TOGGLE, then SETTLE idle cycles before the next grant.
module ff_bank_sequencer #(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 2
) (
    input  logic             Clck,
    input  logic             Reset,
    input  logic             req0_valid,
    input  logic [1:0]       req0_op,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [1:0]       req1_op,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    output logic [WIDTH-1:0] Q,
    output logic             busy,
    output logic             done,
    output logic             grant_id
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_APPLY  = 2'd1,
        ST_SETTLE = 2'd2
    } state_t;

    localparam bit         HAS_SETTLE  = (SETTLE > 0);
    localparam logic [3:0] SETTLE_LOAD = (SETTLE > 0) ? 4'(SETTLE - 1) : 4'd0;

    state_t           state_q;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] bank_q;
    logic [WIDTH-1:0] bank_d;
    logic [3:0]       settleCnt_q;
    logic             busy_q;
    logic             done_q;
    logic             grant_q;
    logic             idle;

    assign idle = (state_q == ST_IDLE) && !Reset;

    // On a tie the requester that did not win last time gets the bank.
    assign req0_ready = idle && req0_valid && (!req1_valid || grant_q);
    assign req1_ready = idle && req1_valid && (!req0_valid || !grant_q);

    always_comb begin
        bank_d = bank_q;
        case (op_q)
            2'b00:   bank_d = data_q;
            2'b01:   bank_d = bank_q | data_q;
            2'b10:   bank_d = bank_q & ~data_q;
            default: bank_d = bank_q ^ data_q;
        endcase
    end

    always_ff @(posedge Clck) begin
        if (Reset) begin
            state_q     <= ST_IDLE;
            op_q        <= 2'b00;
            data_q      <= '0;
            bank_q      <= '0;
            settleCnt_q <= 4'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            grant_q     <= 1'b1;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req0_ready) begin
                        op_q    <= req0_op;
                        data_q  <= req0_data;
                        grant_q <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= ST_APPLY;
                    end else if (req1_ready) begin
                        op_q    <= req1_op;
                        data_q  <= req1_data;
                        grant_q <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= ST_APPLY;
                    end
                end
                ST_APPLY: begin
                    bank_q <= bank_d;
                    done_q <= 1'b1;
                    if (HAS_SETTLE) begin
                        settleCnt_q <= SETTLE_LOAD;
                        state_q     <= ST_SETTLE;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                ST_SETTLE: begin
                    if (settleCnt_q == 4'd0) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        settleCnt_q <= settleCnt_q - 4'd1;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign Q        = bank_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign grant_id = grant_q;

endmodule

// File: tb/tb_ff_bank_sequencer.sv
// Bench for ff_bank_sequencer: directed scenarios plus random traffic, all checked
// against a transaction-level model of the bank, grant and busy window.
module tb_ff_bank_sequencer;

    localparam int W = 4;
    localparam int S = 2;

    logic         Clck = 1'b0;
    logic         Reset;
    logic         r0v, r1v;
    logic [1:0]   r0op, r1op;
    logic [W-1:0] r0d, r1d;
    logic         rdy0, rdy1, busy, done, gid;
    logic [W-1:0] q;

    logic         z1v;
    logic [1:0]   z1op;
    logic [W-1:0] z1d;
    logic         zr0, zr1, zbusy, zdone, zgid;
    logic [W-1:0] zq;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] mQ;
    logic         mGrant;
    logic [1:0]   mOp;
    logic [W-1:0] mData;
    int           busyLeft;
    logic         applyPending;
    logic         expDone;

    ff_bank_sequencer #(.WIDTH(W), .SETTLE(S)) dut (
        .Clck(Clck), .Reset(Reset),
        .req0_valid(r0v), .req0_op(r0op), .req0_data(r0d), .req0_ready(rdy0),
        .req1_valid(r1v), .req1_op(r1op), .req1_data(r1d), .req1_ready(rdy1),
        .Q(q), .busy(busy), .done(done), .grant_id(gid)
    );

    ff_bank_sequencer #(.WIDTH(W), .SETTLE(0)) dut0 (
        .Clck(Clck), .Reset(Reset),
        .req0_valid(1'b0), .req0_op(2'b00), .req0_data(4'h0), .req0_ready(zr0),
        .req1_valid(z1v), .req1_op(z1op), .req1_data(z1d), .req1_ready(zr1),
        .Q(zq), .busy(zbusy), .done(zdone), .grant_id(zgid)
    );

    always #5 Clck = ~Clck;

    function automatic logic [W-1:0] applyOp(input logic [1:0] op, input logic [W-1:0] cur,
                                             input logic [W-1:0] d);
        case (op)
            2'b00:   return d;
            2'b01:   return cur | d;
            2'b10:   return cur & ~d;
            default: return cur ^ d;
        endcase
    endfunction

    function automatic logic expReady0();
        return !Reset && busyLeft == 0 && r0v && (!r1v || mGrant);
    endfunction

    function automatic logic expReady1();
        return !Reset && busyLeft == 0 && r1v && (!r0v || !mGrant);
    endfunction

    task automatic modelEdge();
        if (Reset) begin
            mQ = '0; mGrant = 1'b1; busyLeft = 0; applyPending = 1'b0; expDone = 1'b0;
        end else begin
            expDone = 1'b0;
            if (applyPending) begin
                mQ = applyOp(mOp, mQ, mData);
                expDone = 1'b1;
                applyPending = 1'b0;
            end
            if (busyLeft > 0) begin
                busyLeft--;
            end else if (expReady0()) begin
                mOp = r0op; mData = r0d; mGrant = 1'b0; applyPending = 1'b1; busyLeft = 1 + S;
            end else if (expReady1()) begin
                mOp = r1op; mData = r1d; mGrant = 1'b1; applyPending = 1'b1; busyLeft = 1 + S;
            end
        end
    endtask

    task automatic tick();
        modelEdge();
        @(posedge Clck);
        #1;
    endtask

    task automatic applyStimulus(input logic v0, input logic [1:0] o0, input logic [W-1:0] d0,
                                 input logic v1, input logic [1:0] o1, input logic [W-1:0] d1);
        r0v = v0; r0op = o0; r0d = d0;
        r1v = v1; r1op = o1; r1d = d1;
    endtask

    task automatic test_reset();
        applyStimulus(1'b1, 2'b00, 4'hF, 1'b1, 2'b11, 4'hF);
        Reset = 1'b1;
        tick();
        tick();
        checks++;
        if (q !== 4'h0 || busy !== 1'b0 || done !== 1'b0 || gid !== 1'b1)
            begin errors++; $display("[TB] FAIL reset_state: got q=%b busy=%b done=%b gid=%b expected q=0000 busy=0 done=0 gid=1", q, busy, done, gid); end
        checks++;
        if (rdy0 !== 1'b0 || rdy1 !== 1'b0)
            begin errors++; $display("[TB] FAIL reset_ready: got %b%b expected 00", rdy0, rdy1); end
        Reset = 1'b0;
        applyStimulus(1'b0, 2'b00, 4'h0, 1'b0, 2'b00, 4'h0);
        #1;
        checks++;
        if (rdy0 !== 1'b0 || rdy1 !== 1'b0 || zq !== 4'h0 || zgid !== 1'b1)
            begin errors++; $display("[TB] FAIL reset_idle: got rdy=%b%b zq=%b zgid=%b expected rdy=00 zq=0000 zgid=1", rdy0, rdy1, zq, zgid); end
    endtask

    task automatic test_load();
        int bc;
        applyStimulus(1'b1, 2'b00, 4'b1010, 1'b0, 2'b00, 4'h0);
        #1;
        checks++;
        if (rdy0 !== 1'b1 || rdy1 !== 1'b0)
            begin errors++; $display("[TB] FAIL load_ready: got %b%b expected 10", rdy0, rdy1); end
        tick();
        applyStimulus(1'b0, 2'b11, 4'b0000, 1'b0, 2'b00, 4'h0);
        bc = 0;
        for (int i = 0; i < 20; i++) begin
            if (busy !== 1'b1) break;
            bc++;
            checks++;
            if (i == 1) begin
                if (q !== 4'b1010 || done !== 1'b1)
                    begin errors++; $display("[TB] FAIL load_result: got q=%b done=%b expected q=1010 done=1", q, done); end
            end else if (i == 0) begin
                if (q !== 4'b0000 || done !== 1'b0)
                    begin errors++; $display("[TB] FAIL load_apply_cycle: got q=%b done=%b expected q=0000 done=0", q, done); end
            end else if (done !== 1'b0 || q !== 4'b1010) begin
                errors++; $display("[TB] FAIL load_settle: got q=%b done=%b expected q=1010 done=0", q, done);
            end
            tick();
        end
        checks++;
        if (bc != 1 + S)
            begin errors++; $display("[TB] FAIL load_busy_len: got %0d expected %0d", bc, 1 + S); end
    endtask

    task automatic test_ops();
        logic [1:0]   ops  [3] = '{2'b01, 2'b10, 2'b11};
        logic [W-1:0] dats [3] = '{4'b0101, 4'b0011, 4'b1111};
        logic [W-1:0] exps [3] = '{4'b1111, 4'b1100, 4'b0011};
        for (int j = 0; j < 3; j++) begin
            applyStimulus(1'b1, ops[j], dats[j], 1'b0, 2'b00, 4'h0);
            #1;
            checks++;
            if (rdy0 !== 1'b1)
                begin errors++; $display("[TB] FAIL ops_ready[%0d]: got %b expected 1", j, rdy0); end
            tick();
            applyStimulus(1'b0, 2'b00, 4'h0, 1'b0, 2'b00, 4'h0);
            tick();
            checks++;
            if (q !== exps[j] || done !== 1'b1)
                begin errors++; $display("[TB] FAIL ops_result[%0d]: got q=%b done=%b expected q=%b done=1", j, q, done, exps[j]); end
            for (int i = 0; i < 20 && busy === 1'b1; i++) tick();
            checks++;
            if (busy !== 1'b0)
                begin errors++; $display("[TB] FAIL ops_idle[%0d]: got busy=%b expected 0", j, busy); end
        end
    endtask

    task automatic test_round_robin();
        int   k;
        logic w, expW;
        Reset = 1'b1;
        applyStimulus(1'b0, 2'b00, 4'h0, 1'b0, 2'b00, 4'h0);
        tick();
        Reset = 1'b0;
        k = 0;
        for (int i = 0; i < 40 && k < 4; i++) begin
            applyStimulus(1'b1, 2'b00, 4'($urandom), 1'b1, 2'b00, 4'($urandom));
            #1;
            if (rdy0 === 1'b1 || rdy1 === 1'b1) begin
                w = rdy1;
                expW = (k % 2 == 1);
                checks++;
                if ((rdy0 && rdy1) || w !== expW)
                    begin errors++; $display("[TB] FAIL rr_winner[%0d]: got rdy=%b%b expected winner %b", k, rdy0, rdy1, expW); end
                tick();
                checks++;
                if (gid !== expW)
                    begin errors++; $display("[TB] FAIL rr_grant[%0d]: got %b expected %b", k, gid, expW); end
                k++;
            end else begin
                tick();
            end
        end
        checks++;
        if (k != 4)
            begin errors++; $display("[TB] FAIL rr_count: got %0d grants expected 4", k); end
        applyStimulus(1'b0, 2'b00, 4'h0, 1'b0, 2'b00, 4'h0);
    endtask

    task automatic test_hold();
        int hsAt[$];
        for (int i = 0; i < 20 && busy === 1'b1; i++) tick();
        for (int i = 0; i < 30; i++) begin
            applyStimulus(1'b1, 2'($urandom), 4'($urandom), 1'b0, 2'b00, 4'h0);
            #1;
            checks++;
            if (rdy0 !== expReady0())
                begin errors++; $display("[TB] FAIL hold_ready[%0d]: got %b expected %b", i, rdy0, expReady0()); end
            if (rdy0 === 1'b1) hsAt.push_back(i);
            tick();
            checks++;
            if (q !== mQ)
                begin errors++; $display("[TB] FAIL hold_q[%0d]: got %b expected %b", i, q, mQ); end
        end
        checks++;
        if (hsAt.size() < 2 || hsAt[1] - hsAt[0] != 2 + S)
            begin errors++; $display("[TB] FAIL hold_gap: got %0d handshakes, gap %0d expected gap %0d", hsAt.size(), (hsAt.size() >= 2) ? hsAt[1] - hsAt[0] : -1, 2 + S); end
        applyStimulus(1'b0, 2'b00, 4'h0, 1'b0, 2'b00, 4'h0);
    endtask

    task automatic test_reset_apply();
        for (int i = 0; i < 20 && busy === 1'b1; i++) tick();
        applyStimulus(1'b1, 2'b00, 4'b0101, 1'b0, 2'b00, 4'h0);
        tick();
        applyStimulus(1'b0, 2'b00, 4'h0, 1'b0, 2'b00, 4'h0);
        for (int i = 0; i < 20 && busy === 1'b1; i++) tick();
        checks++;
        if (q !== 4'b0101)
            begin errors++; $display("[TB] FAIL rst_apply_setup: got %b expected 0101", q); end
        applyStimulus(1'b1, 2'b11, 4'b1111, 1'b0, 2'b00, 4'h0);
        #1;
        checks++;
        if (rdy0 !== 1'b1)
            begin errors++; $display("[TB] FAIL rst_apply_hs: got %b expected 1", rdy0); end
        tick();
        checks++;
        if (gid !== 1'b0 || busy !== 1'b1)
            begin errors++; $display("[TB] FAIL rst_apply_grant: got gid=%b busy=%b expected gid=0 busy=1", gid, busy); end
        Reset = 1'b1;
        applyStimulus(1'b0, 2'b00, 4'h0, 1'b0, 2'b00, 4'h0);
        tick();
        Reset = 1'b0;
        checks++;
        if (q !== 4'h0 || done !== 1'b0 || gid !== 1'b1 || busy !== 1'b0)
            begin errors++; $display("[TB] FAIL rst_apply: got q=%b done=%b gid=%b busy=%b expected q=0000 done=0 gid=1 busy=0", q, done, gid, busy); end
        tick();
        checks++;
        if (q !== 4'h0 || done !== 1'b0 || busy !== 1'b0)
            begin errors++; $display("[TB] FAIL rst_apply_after: got q=%b done=%b busy=%b expected q=0000 done=0 busy=0", q, done, busy); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'($urandom), 2'($urandom), 4'($urandom),
                          1'($urandom), 2'($urandom), 4'($urandom));
            Reset = ($urandom_range(0, 49) == 0);
            #1;
            checks++;
            if (rdy0 !== expReady0() || rdy1 !== expReady1())
                begin errors++; $display("[TB] FAIL rand_ready[%0d]: got %b%b expected %b%b", i, rdy0, rdy1, expReady0(), expReady1()); end
            tick();
            checks++;
            if (q !== mQ || busy !== (busyLeft > 0) || done !== expDone || gid !== mGrant)
                begin errors++; $display("[TB] FAIL rand_state[%0d]: got q=%b busy=%b done=%b gid=%b expected q=%b busy=%b done=%b gid=%b", i, q, busy, done, gid, mQ, (busyLeft > 0), expDone, mGrant); end
        end
        Reset = 1'b0;
        applyStimulus(1'b0, 2'b00, 4'h0, 1'b0, 2'b00, 4'h0);
    endtask

    task automatic test_back_to_back();
        logic         zIdle, zPend, zDone;
        logic [W-1:0] zQ;
        int           dutHs;
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        z1v = 1'b1; z1op = 2'b11; z1d = 4'b0001;
        zIdle = 1'b1; zPend = 1'b0; zDone = 1'b0; zQ = '0; dutHs = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            checks++;
            if (zr1 !== zIdle)
                begin errors++; $display("[TB] FAIL b2b_ready[%0d]: got %b expected %b", i, zr1, zIdle); end
            if (zr1 === 1'b1) dutHs++;
            if (zPend) begin
                zQ = zQ ^ 4'b0001; zDone = 1'b1; zPend = 1'b0; zIdle = 1'b1;
            end else begin
                zDone = 1'b0;
                if (zIdle) begin zPend = 1'b1; zIdle = 1'b0; end
            end
            tick();
            checks++;
            if (zq !== zQ || zdone !== zDone)
                begin errors++; $display("[TB] FAIL b2b_q[%0d]: got q=%b done=%b expected q=%b done=%b", i, zq, zdone, zQ, zDone); end
        end
        z1v = 1'b0;
        checks++;
        if (dutHs != 10)
            begin errors++; $display("[TB] FAIL b2b_count: got %0d handshakes expected 10", dutHs); end
    endtask

    initial begin
        Reset = 1'b1;
        z1v = 1'b0; z1op = 2'b00; z1d = 4'h0;
        mQ = '0; mGrant = 1'b1; mOp = 2'b00; mData = '0;
        busyLeft = 0; applyPending = 1'b0; expDone = 1'b0;
        applyStimulus(1'b0, 2'b00, 4'h0, 1'b0, 2'b00, 4'h0);
        test_reset();
        test_load();
        test_ops();
        test_round_robin();
        test_hold();
        test_reset_apply();
        test_random();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
